// File: rtl/viterbi_chan_pkg.sv
// viterbi_chan_pkg
// Shared types and helpers for the channel-impairment blocks in the
// tx/rx Viterbi harness.
//   inj_state_t : injector FSM states (IDLE / BURST / GAP)
//   inj_mode_t  : error-mask selection codes on mode_i
//   LFSR_TAPS   : feedback taps of the 16-bit Fibonacci LFSR,
//                 x^16 + x^14 + x^13 + x^11 + 1
//   popcount8   : number of set bits in an 8-bit vector
package viterbi_chan_pkg;

  typedef enum logic [1:0] {
    INJ_IDLE  = 2'd0,
    INJ_BURST = 2'd1,
    INJ_GAP   = 2'd2
  } inj_state_t;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_LFSR = 2'd1,
    MODE_ROT  = 2'd2,
    MODE_ALL  = 2'd3
  } inj_mode_t;

  // The shift register moves toward the MSB. The exponents 16, 14, 13 and 11
  // map to state bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/chan_lfsr16.sv
// chan_lfsr16
// 16-bit Fibonacci LFSR. Later noise blocks reuse it as a generic
// pseudo-random source.
//   clk   : clock, rising edge
//   rst   : synchronous active-low reset; loads seed
//   seed  : reload value, must be nonzero
//   load  : reload seed this cycle; takes priority over adv
//   adv   : advance one step this cycle
//   value : current register contents
module chan_lfsr16
  import viterbi_chan_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  input  logic        load,
  input  logic        adv,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;
  logic        fb;

  assign fb    = ^(lfsr_q & LFSR_TAPS);
  assign value = lfsr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= seed;
    end else if (load) begin
      lfsr_q <= seed;
    end else if (adv) begin
      lfsr_q <= {lfsr_q[14:0], fb};
    end
  end

endmodule

// File: rtl/viterbi_chan_inj.sv
// viterbi_chan_inj
// Channel-impairment stage placed between the convolutional encoder and the
// Viterbi decoder. It registers each encoded symbol and corrupts the first
// b_l symbols of every p_l-symbol period while run_i is high.
//
// Stream handshake: the stream has no ready signal. A symbol transfers on
// every rising edge where valid_i is 1. valid_o repeats valid_i exactly one
// cycle later. Nothing back-pressures this stage.
//
// Ports
//   clk, rst        : clock; synchronous active-low reset
//   valid_i, sym_i  : input symbol stream
//   run_i           : injection enable (level)
//   clr_i           : synchronous clear of the statistics counters
//   mode_i          : 0 pass, 1 LFSR bit, 2 rotating bit, 3 all bits
//   period_i        : symbols per period (0 = no injection)
//   burst_i         : corrupted symbols at the start of each period
//   valid_o, sym_o  : registered stream, sym_o = sym_i ^ err_mask_o
//   err_mask_o      : bits flipped in sym_o
//   inj_o           : sym_o is corrupted this cycle
//   err_cnt_o       : corrupted symbols since clear (saturating)
//   bit_err_cnt_o   : flipped bits since clear (saturating)
//   sym_cnt_o       : valid symbols seen while running (saturating)
//   dbg_state_o     : current injector FSM state (inj_state_t encoding)
//
// Build option: define CHAN_INJ_STATS_EN to implement the statistics
// counters. Without it the three counters read 0 and clr_i has no effect.
module viterbi_chan_inj
  import viterbi_chan_pkg::*;
#(
  parameter int          SYM_W     = 2,
  parameter int          PER_W     = 8,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [SYM_W-1:0] sym_i,
  input  logic             run_i,
  input  logic             clr_i,
  input  logic [1:0]       mode_i,
  input  logic [PER_W-1:0] period_i,
  input  logic [PER_W-1:0] burst_i,
  output logic             valid_o,
  output logic [SYM_W-1:0] sym_o,
  output logic [SYM_W-1:0] err_mask_o,
  output logic             inj_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] bit_err_cnt_o,
  output logic [CNT_W-1:0] sym_cnt_o,
  output logic [1:0]       dbg_state_o
);

  localparam int ROT_W = (SYM_W > 1) ? $clog2(SYM_W) : 1;
  localparam logic [SYM_W-1:0] ONE_HOT0 = SYM_W'(1);
  localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(SYM_W - 1);

  inj_state_t       state, state_nxt;
  logic [PER_W-1:0] pos, pos_nxt;
  logic [PER_W-1:0] p_l, p_nxt;
  logic [PER_W-1:0] b_l, b_nxt;
  logic [ROT_W-1:0] rot;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_idx;
  logic             lfsr_load;
  logic [SYM_W-1:0] mask;
  logic             new_burst;

  assign dbg_state_o = state;

  // ---------------- LFSR ----------------
  // The LFSR steps on every accepted symbol. It is reseeded when the FSM
  // leaves IDLE, so every run starts from the same sequence.
  assign lfsr_load = (state == INJ_IDLE) && run_i;

  chan_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .seed  (LFSR_SEED),
    .load  (lfsr_load),
    .adv   (valid_i),
    .value (lfsr)
  );

  // ---------------- error mask ----------------
  always_comb begin
    mask     = '0;
    lfsr_idx = lfsr % 16'(SYM_W);
    if (state == INJ_BURST) begin
      case (inj_mode_t'(mode_i))
        MODE_PASS: mask = '0;
        MODE_LFSR: mask = ONE_HOT0 << lfsr_idx;
        MODE_ROT:  mask = ONE_HOT0 << rot;
        MODE_ALL:  mask = '1;
        default:   mask = '0;
      endcase
    end
  end

  // ---------------- FSM / position ----------------
  // A newly latched period starts in BURST only if both its period and its
  // burst are nonzero. A zero in either one holds the FSM in GAP. In that
  // case the FSM re-latches on every symbol, so new settings take effect
  // at once.
  assign new_burst = (period_i != '0) && (burst_i != '0);

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    p_nxt     = p_l;
    b_nxt     = b_l;
    if (!run_i) begin
      state_nxt = INJ_IDLE;
      pos_nxt   = '0;
    end else if (state == INJ_IDLE) begin
      pos_nxt   = '0;
      p_nxt     = period_i;
      b_nxt     = burst_i;
      state_nxt = new_burst ? INJ_BURST : INJ_GAP;
    end else if (valid_i) begin
      if ((p_l == '0) || (b_l == '0) || (pos == p_l - 1'b1)) begin
        pos_nxt   = '0;
        p_nxt     = period_i;
        b_nxt     = burst_i;
        state_nxt = new_burst ? INJ_BURST : INJ_GAP;
      end else begin
        pos_nxt   = pos + 1'b1;
        state_nxt = (pos_nxt < b_l) ? INJ_BURST : INJ_GAP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= INJ_IDLE;
      pos   <= '0;
      p_l   <= '0;
      b_l   <= '0;
    end else begin
      state <= state_nxt;
      pos   <= pos_nxt;
      p_l   <= p_nxt;
      b_l   <= b_nxt;
    end
  end

  // ---------------- output register ----------------
  // sym_o and err_mask_o hold between symbols. inj_o is a one-cycle flag
  // that marks only the cycle that carries the corrupted symbol.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_o    <= 1'b0;
      sym_o      <= '0;
      err_mask_o <= '0;
      inj_o      <= 1'b0;
      rot        <= '0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        sym_o      <= sym_i ^ mask;
        err_mask_o <= mask;
        inj_o      <= |mask;
        if ((state == INJ_BURST) && (mode_i == MODE_ROT)) begin
          rot <= (rot == ROT_LAST) ? '0 : rot + 1'b1;
        end
      end else begin
        inj_o <= 1'b0;
      end
    end
  end

  // ---------------- statistics ----------------
`ifdef CHAN_INJ_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             count_en;
  logic [3:0]       mask_bits;
  logic [CNT_W+3:0] bit_sum;

  assign count_en  = valid_i && (state != INJ_IDLE);
  assign mask_bits = popcount8(8'(mask));
  // The sum has four extra bits, so an overflow of the popcount add is
  // visible and the counter can clamp instead of wrapping.
  assign bit_sum   = {4'b0000, bit_err_cnt_o} + {{CNT_W{1'b0}}, mask_bits};

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt_o     <= '0;
      bit_err_cnt_o <= '0;
      sym_cnt_o     <= '0;
    end else if (clr_i) begin
      err_cnt_o     <= '0;
      bit_err_cnt_o <= '0;
      sym_cnt_o     <= '0;
    end else if (count_en) begin
      if (sym_cnt_o != CNT_MAX) begin
        sym_cnt_o <= sym_cnt_o + 1'b1;
      end
      if ((|mask) && (err_cnt_o != CNT_MAX)) begin
        err_cnt_o <= err_cnt_o + 1'b1;
      end
      bit_err_cnt_o <= (bit_sum[CNT_W+3:CNT_W] != 4'b0000) ? CNT_MAX
                                                           : bit_sum[CNT_W-1:0];
    end
  end
`else
  logic unused_clr;
  assign unused_clr    = clr_i;
  assign err_cnt_o     = '0;
  assign bit_err_cnt_o = '0;
  assign sym_cnt_o     = '0;
`endif

endmodule
